// File: rtl/door_latch_ctrl.sv
// door_latch_ctrl
// Door latch controller. A rising edge on unlock releases the latch for a
// bounded window; opening the door inside that window moves to OPENED, and a
// door left open too long raises the alarm. Closing the door always relocks.
//
// Parameters:
//   OPEN_CYCLES  cycles the latch stays released waiting for the door (2..255)
//   AJAR_LIMIT   cycles the door may stay open before the alarm (2..255)
//
// Ports:
//   clk            single clock, rising edge
//   reset          asynchronous, active-high reset
//   unlock         level from the code-sequence detector; only its rise counts
//   door_open      door sensor, synchronous to clk; 1 = open
//   latch_release  latch solenoid drive; 1 = released
//   alarm          1 = alarm active
//   state          state code: 00 LOCKED, 01 RELEASED, 10 OPENED, 11 ALARM
//
// Build option:
//   FORCED_ENTRY_EN  when defined, the door opening while LOCKED (without a
//                    same-cycle unlock rise) goes straight to ALARM.

module door_latch_ctrl #(
  parameter int unsigned OPEN_CYCLES = 8,
  parameter int unsigned AJAR_LIMIT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       unlock,
  input  logic       door_open,
  output logic       latch_release,
  output logic       alarm,
  output logic [1:0] state
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {
    LOCKED   = 2'b00,
    RELEASED = 2'b01,
    OPENED   = 2'b10,
    ALARM    = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] OPEN_LAST = CNT_W'(OPEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] AJAR_LAST = CNT_W'(AJAR_LIMIT - 1);

  state_t           state_q;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             unlock_q;
  logic             unlock_rise;

  // Edge detect: a held unlock level must never re-release the latch.
  assign unlock_rise = unlock & ~unlock_q;

  // Next-state function of the Moore machine.
  function automatic state_t next_state(
    input state_t           cur,
    input logic             rise,
    input logic             door,
    input logic [CNT_W-1:0] count
  );
    state_t nxt;
    nxt = cur;
    case (cur)
      LOCKED: begin
        if (rise) begin
          nxt = RELEASED;
        end
`ifdef FORCED_ENTRY_EN
        else if (door) begin
          // Door opened without a valid code: forced entry.
          nxt = ALARM;
        end
`endif
      end
      RELEASED: begin
        // Door opening wins over the release window expiring.
        if (door) begin
          nxt = OPENED;
        end else if (count == OPEN_LAST) begin
          nxt = LOCKED;
        end
      end
      OPENED: begin
        // A close in the limit cycle relocks rather than alarming.
        if (!door) begin
          nxt = LOCKED;
        end else if (count == AJAR_LAST) begin
          nxt = ALARM;
        end
      end
      ALARM: begin
        if (!door) begin
          nxt = LOCKED;
        end
      end
      default: nxt = LOCKED;
    endcase
    return nxt;
  endfunction

  assign state_nxt = next_state(state_q, unlock_rise, door_open, cnt);

  // State, dwell counter, unlock history and registered Moore outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LOCKED;
      cnt           <= '0;
      unlock_q      <= 1'b0;
      latch_release <= 1'b0;
      alarm         <= 1'b0;
    end else begin
      unlock_q      <= unlock;
      state_q       <= state_nxt;
      // Counter measures time spent in the current state.
      if (state_nxt != state_q) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      // Outputs load the decode of the state being entered, so they always
      // equal a decode of state_q and never depend on inputs after the edge.
      latch_release <= (state_nxt == RELEASED);
      alarm         <= (state_nxt == ALARM);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_door_latch_ctrl.sv
// Testbench for door_latch_ctrl with OPEN_CYCLES=4, AJAR_LIMIT=6.
// The driver applies one input vector per cycle at the falling edge and
// pushes the hand-computed state expected after the next rising edge; a
// monitor pops and checks state, latch_release and alarm after each edge.

module tb_door_latch_ctrl;

  localparam logic [1:0] S_L = 2'b00;
  localparam logic [1:0] S_R = 2'b01;
  localparam logic [1:0] S_O = 2'b10;
  localparam logic [1:0] S_A = 2'b11;

  logic       clk;
  logic       reset;
  logic       unlock;
  logic       door_open;
  logic       latch_release;
  logic       alarm;
  logic [1:0] state;

  typedef struct {
    logic [1:0] st;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   total;
  int   bad;

  door_latch_ctrl #(
    .OPEN_CYCLES(4),
    .AJAR_LIMIT (6)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .unlock       (unlock),
    .door_open    (door_open),
    .latch_release(latch_release),
    .alarm        (alarm),
    .state        (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic [1:0] exp_st);
    chk({tag, ".state"}, state, exp_st);
    chk({tag, ".latch"}, {1'b0, latch_release}, {1'b0, exp_st == S_R});
    chk({tag, ".alarm"}, {1'b0, alarm}, {1'b0, exp_st == S_A});
  endtask

  // Called at a falling edge: drive inputs, queue expectation, advance a cycle.
  task automatic step(input logic u, input logic d, input logic [1:0] exp_st,
                      input string tag);
    exp_t e;
    unlock    = u;
    door_open = d;
    e.st      = exp_st;
    e.tag     = tag;
    q.push_back(e);
    @(negedge clk);
  endtask

  // Monitor: compare one queued expectation after every rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk_all(e.tag, e.st);
      end
    end
  end

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    unlock    = 1'b0;
    door_open = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", S_L);
    reset = 1'b0;

    // Single unlock pulse, door never opens: exactly 4 released cycles.
    step(1, 0, S_R, "pulse0");
    step(0, 0, S_R, "pulse1");
    step(0, 0, S_R, "pulse2");
    step(0, 0, S_R, "pulse3");
    step(0, 0, S_L, "pulse4");
    step(0, 0, S_L, "pulse5");

    // Unlock held 20 cycles: only one release.
    step(1, 0, S_R, "held0");
    for (int i = 1; i < 4; i++) step(1, 0, S_R, "held_r");
    for (int i = 4; i < 20; i++) step(1, 0, S_L, "held_l");
    step(0, 0, S_L, "held_end");

    // Door opens on third released cycle for 3 cycles, then closes.
    step(1, 0, S_R, "open0");
    step(0, 0, S_R, "open1");
    step(0, 0, S_R, "open2");
    step(0, 1, S_O, "open3");
    step(0, 1, S_O, "open4");
    step(0, 1, S_O, "open5");
    step(0, 0, S_L, "open6");

    // Door stays open: alarm after the 6th opened cycle, clears on close.
    step(1, 0, S_R, "ajar_r");
    for (int i = 0; i < 6; i++) step(0, 1, S_O, "ajar_o");
    step(0, 1, S_A, "ajar_a0");
    step(0, 1, S_A, "ajar_a1");
    step(0, 0, S_L, "ajar_close");

    // Close in the limit cycle wins over the alarm.
    step(1, 0, S_R, "lim_r");
    for (int i = 0; i < 6; i++) step(0, 1, S_O, "lim_o");
    step(0, 0, S_L, "lim_close");

    // Door opens in the same cycle the release window expires.
    step(1, 0, S_R, "edge0");
    step(0, 0, S_R, "edge1");
    step(0, 0, S_R, "edge2");
    step(0, 0, S_R, "edge3");
    step(0, 1, S_O, "edge4");
    step(0, 0, S_L, "edge5");

    // Door opened while locked with no unlock.
`ifdef FORCED_ENTRY_EN
    step(0, 1, S_A, "force0");
    step(0, 1, S_A, "force1");
`else
    step(0, 1, S_L, "force0");
    step(0, 1, S_L, "force1");
`endif
    step(0, 0, S_L, "force2");
    // Unlock rise and open door together: the rise wins.
    step(1, 1, S_R, "both0");
    step(0, 1, S_O, "both1");
    step(0, 0, S_L, "both2");

    // Reset asserted mid-release takes effect before the next edge.
    step(1, 0, S_R, "mid0");
    step(0, 0, S_R, "mid1");
    @(posedge clk);
    #2;
    reset  = 1'b1;
    unlock = 1'b1;
    #1;
    chk_all("async_reset", S_L);
    @(negedge clk);
    @(negedge clk);
    chk_all("in_reset", S_L);
    reset = 1'b0;
    // Unlock already high when reset releases counts as a rise.
    step(1, 0, S_R, "post0");
    step(1, 0, S_R, "post1");
    step(0, 0, S_R, "post2");
    step(0, 0, S_R, "post3");
    step(0, 0, S_L, "post4");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #2;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
